gpr_debug_port: RTL
===================

# gpr_debug_port

Debug/host access controller that drives the write/read port of the 32-entry general-purpose register file (write address shared with read port 2, combinational read, r0 reads as zero). It accepts read, write and clear commands over a valid/ready handshake, arbitrates them against the core's writeback, and returns results on a valid/ready response channel. It sits between the debug interface and the register file, muxed in front of the core writeback path.

## Interface
- N, 8, data width of a register; must match the register file.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  00 read, 01 write, 10 clear-all, 11 reserved.
- cmd_addr  in  5  target register.
- cmd_wdata  in  N  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_data  out  N  read data; 0 for write/clear/error responses.
- rsp_err  out  1  command rejected: write to r0, reserved op, or clear when compiled out.
- busy  out  1  state != IDLE.
- core_we  in  1  core writeback strobe; has absolute priority.
- core_addr  in  5  core writeback address.
- core_wdata  in  N  core writeback data.
- rf_we  out  1  to register file write enable.
- rf_addr  out  5  to register file port-2 address, which is also the write address.
- rf_wdata  out  N  to register file write data.
- rf_rdata  in  N  from register file port-2 read data.

## Operation
- States: IDLE, EXEC, CLR, RESP.
- IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch op/addr/wdata, clear rsp_err, go EXEC.
- Port mux: when core_we=1, rf_we/rf_addr/rf_wdata = core signals combinationally, in every state. Otherwise, in EXEC/CLR the outputs carry the debug access. Otherwise rf_we=0, rf_addr=latched addr, rf_wdata=0.
- EXEC with core_we=1: stall and hold state. No debug access that cycle.
- EXEC with core_we=0:
  - read: register rf_rdata into rsp_data, go RESP.
  - write with addr!=0: rf_we=1 for exactly this cycle, go RESP.
  - write with addr==0: no rf_we, rsp_err=1, go RESP.
  - reserved op: rsp_err=1, go RESP.
  - clear: 5-bit counter=1, go CLR, no write this cycle.
- CLR: each cycle with core_we=0, rf_we=1, rf_addr=counter, rf_wdata=0, counter++. After writing address 31, go RESP. While core_we=1, the counter holds.
- RESP: rsp_valid=1. Hold rsp_data/rsp_err stable until rsp_ready. On rsp_valid&rsp_ready go IDLE and clear rsp_data/rsp_err to 0.
- A core write to a register already swept during clear persists. A core write to a not-yet-swept register is overwritten with 0.
- rf_we is never asserted with rf_addr=0 by the debug path.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, counter 0, latched fields 0. rf_* follow core_* (rf_we=0 when core_we=0).
- Reset asserted mid-operation: abort immediately. No further debug rf_we. Pending response dropped.
- Read/write with no core contention:
  - accept at cycle 0.
  - EXEC at cycle 1: write commits at the end of cycle 1; read samples at the end of cycle 1.
  - rsp_valid from cycle 2.
- Each core_we cycle in EXEC/CLR adds exactly one cycle of latency.
- Clear, uncontended: accept at 0, EXEC at 1, CLR cycles 2..32 (31 writes), rsp_valid at 33.
- Minimum command spacing is 3 cycles: response handshake, then IDLE, then accept. cmd_ready is combinational from state only.
- A read issued after a debug write to the same register returns the new value.

## Configuration
- REGDBG_CLEAR_EN defined: op 10 performs the clear sweep as described.
- REGDBG_CLEAR_EN undefined: op 10 is treated as reserved (rsp_err=1, no writes). The CLR state and counter are absent from the RTL.

## Test plan
- Write r5=0xA5, then read r5: rf_we high for exactly one cycle with rf_addr=5, rf_wdata=0xA5. Read response rsp_data=0xA5, rsp_err=0, rsp_valid at cycle 2 after accept.
- Write r0=0xFF: no rf_we, rsp_err=1. A subsequent read of r0 returns 0x00.
- Read r7 while core_we=1 (r7←0x3C) in the EXEC cycle: a one-cycle stall, then rsp_data=0x3C. Core write appears on rf_* in the same cycle it is asserted.
- Clear after filling r1..r31 with 0xFF, with core_we pulsed for 2 cycles mid-sweep: 31 debug writes of 0 to addresses 1..31 in order, rsp_valid at cycle 35. All registers read 0 afterwards except core writes to already-swept addresses.
- rsp_ready held low for 5 cycles: rsp_valid/rsp_data stable, cmd_ready=0, a new cmd_valid is ignored. Assert reset during CLR: busy=0, rsp_valid=0, no further rf_we.
- Build without REGDBG_CLEAR_EN: op 10 and op 11 both give rsp_err=1 with no rf_we.

Source files
------------

// File: rtl/gpr_debug_port_if.sv
// Debug command/response channels of gpr_debug_port: host drives commands
// (master), the controller accepts them and returns responses (slave).
interface gpr_debug_port_if #(
  parameter int N = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [4:0]   cmd_addr;
  logic [N-1:0] cmd_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/gpr_debug_port.sv
// Debug/host access controller muxed in front of the core writeback into the GPR file.
// Define REGDBG_CLEAR_EN to build the clear-all sweep (op 10); otherwise op 10 is rejected.
module gpr_debug_port #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            reset,
  gpr_debug_port_if.slave dbg,
  output logic            busy,
  input  logic            core_we,
  input  logic [4:0]      core_addr,
  input  logic [N-1:0]    core_wdata,
  output logic            rf_we,
  output logic [4:0]      rf_addr,
  output logic [N-1:0]    rf_wdata,
  input  logic [N-1:0]    rf_rdata
);
  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // EXEC  | perform read/write or start the clear; stalls while core_we
  // CLR   | sweep zeros into r1..r31, holding while core_we
  // RESP  | response held until rsp_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
`ifdef REGDBG_CLEAR_EN
  localparam logic [1:0] S_CLR  = 2'd2;
`endif
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;

  logic [1:0]   state;
  logic [1:0]   op_q;
  logic [4:0]   addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] rsp_data_q;
  logic         rsp_err_q;
`ifdef REGDBG_CLEAR_EN
  logic [4:0]   clr_cnt;
`endif

  logic         dbg_we;
  logic [4:0]   dbg_addr;
  logic [N-1:0] dbg_wdata;

  assign dbg.cmd_ready = (state == S_IDLE);
  assign dbg.rsp_valid = (state == S_RESP);
  assign dbg.rsp_data  = rsp_data_q;
  assign dbg.rsp_err   = rsp_err_q;
  assign busy          = (state != S_IDLE);

  // Debug-side port request; r0 is never targeted (clear counter starts at 1).
  always_comb begin
    dbg_we    = 1'b0;
    dbg_addr  = addr_q;
    dbg_wdata = '0;
    if (state == S_EXEC && op_q == OP_WR && addr_q != 5'd0) begin
      dbg_we    = 1'b1;
      dbg_wdata = wdata_q;
    end
`ifdef REGDBG_CLEAR_EN
    if (state == S_CLR) begin
      dbg_we   = 1'b1;
      dbg_addr = clr_cnt;
    end
`endif
  end

  always_comb begin
    if (core_we) begin
      rf_we    = 1'b1;
      rf_addr  = core_addr;
      rf_wdata = core_wdata;
    end else begin
      rf_we    = dbg_we;
      rf_addr  = dbg_addr;
      rf_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= 2'd0;
      addr_q     <= 5'd0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef REGDBG_CLEAR_EN
      clr_cnt    <= 5'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (dbg.cmd_valid) begin
            op_q      <= dbg.cmd_op;
            addr_q    <= dbg.cmd_addr;
            wdata_q   <= dbg.cmd_wdata;
            rsp_err_q <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!core_we) begin
            case (op_q)
              OP_RD: begin
                rsp_data_q <= rf_rdata;
                state      <= S_RESP;
              end
              OP_WR: begin
                if (addr_q == 5'd0) rsp_err_q <= 1'b1;
                state <= S_RESP;
              end
`ifdef REGDBG_CLEAR_EN
              OP_CLR: begin
                clr_cnt <= 5'd1;
                state   <= S_CLR;
              end
`endif
              default: begin
                rsp_err_q <= 1'b1;
                state     <= S_RESP;
              end
            endcase
          end
        end
`ifdef REGDBG_CLEAR_EN
        S_CLR: begin
          if (!core_we) begin
            clr_cnt <= clr_cnt + 5'd1;
            if (clr_cnt == 5'd31) state <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          if (dbg.rsp_ready) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
